// File: rtl/cpu_control_pkg.sv
// Shared types, opcode/funct constants and the instruction decoder for cpu_control.
// Optional MUL support is compiled in when CPU_CONTROL_MUL_EN is defined.
package cpu_control_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} fsm_state_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_MUL, ALU_LUI
   } alu_op_t;

   typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_ILLEGAL} kind_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef struct packed {
      kind_t       kind;
      alu_op_t     alu_op;
      logic        use_imm;
      logic        br_ne;
      logic [31:0] imm;
   } decode_t;

   function automatic alu_op_t base_op(input logic [2:0] f3);
      case (f3)
         F3_AND:  return ALU_AND;
         F3_OR:   return ALU_OR;
         F3_XOR:  return ALU_XOR;
         F3_SLT:  return ALU_SLT;
         F3_SLL:  return ALU_SLL;
         F3_SRL:  return ALU_SRL;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic decode_t decode(input logic [31:0] instr);
      decode_t    d;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = instr[14:12];
      f7 = instr[31:25];
      d  = '{kind: K_ILLEGAL, alu_op: ALU_ADD, use_imm: 1'b1, br_ne: instr[12], imm: '0};
      case (instr[6:0])
         OP_LUI: begin
            d.kind   = K_ALU;
            d.alu_op = ALU_LUI;
            d.imm    = {instr[31:12], 12'h000};
         end
         OP_IMM: begin
            d.imm    = {{20{instr[31]}}, instr[31:20]};
            d.alu_op = base_op(f3);
            // Immediate shifts are not part of the subset.
            if (f3 != F3_SLL && f3 != F3_SRL) d.kind = K_ALU;
         end
         OP_REG: begin
            d.use_imm = 1'b0;
            if (f7 == F7_BASE) begin
               d.kind   = K_ALU;
               d.alu_op = base_op(f3);
            end else if (f7 == F7_ALT && f3 == F3_ADD) begin
               d.kind   = K_ALU;
               d.alu_op = ALU_SUB;
            end
`ifdef CPU_CONTROL_MUL_EN
            else if (f7 == F7_MULDIV && f3 == F3_ADD) begin
               d.kind   = K_ALU;
               d.alu_op = ALU_MUL;
            end
`endif
         end
         OP_LOAD: begin
            d.imm = {{20{instr[31]}}, instr[31:20]};
            if (f3 == F3_WORD) d.kind = K_LOAD;
         end
         OP_STORE: begin
            d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            if (f3 == F3_WORD) d.kind = K_STORE;
         end
         OP_BRANCH: begin
            d.use_imm = 1'b0;
            d.imm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            if (f3 == F3_BEQ || f3 == F3_BNE) d.kind = K_BRANCH;
         end
         OP_JAL: begin
            d.kind = K_JAL;
            d.imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         default: ;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
         ALU_SLL: return a << b[4:0];
         ALU_SRL: return a >> b[4:0];
         ALU_MUL: return a * b;
         ALU_LUI: return b;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_control_byte_mem.sv
// Byte-addressed memory: combinational big-endian word read, synchronous 4-byte write.
// Address is a word index, so the low two byte-address bits are implicitly zero.
module byte_mem #(
   parameter int BYTES = 4096
) (
   input  logic                       clk,
   input  logic [$clog2(BYTES)-1:2]   word_addr,
   output logic [31:0]                rdata,
   input  logic                       we,
   input  logic [31:0]                wdata
);
   // NOTE: storage has no reset; it is zero only at power-up, so rst never disturbs contents.
   logic [7:0] memory_bank [BYTES] = '{default: 8'h00};

   assign rdata = {memory_bank[{word_addr, 2'b00}], memory_bank[{word_addr, 2'b01}],
                   memory_bank[{word_addr, 2'b10}], memory_bank[{word_addr, 2'b11}]};

   always_ff @(posedge clk) begin
      if (we) begin
         memory_bank[{word_addr, 2'b00}] <= wdata[31:24];
         memory_bank[{word_addr, 2'b01}] <= wdata[23:16];
         memory_bank[{word_addr, 2'b10}] <= wdata[15:8];
         memory_bank[{word_addr, 2'b11}] <= wdata[7:0];
      end
   end
endmodule

// File: rtl/cpu_control.sv
// Multi-cycle RV32I-subset core with separate instruction and data byte memories.
// Define CPU_CONTROL_MUL_EN to enable the MUL instruction; otherwise it halts the core.
module cpu_control
   import cpu_control_pkg::*;
#(
   parameter int IMEM_BYTES = 4096,
   parameter int DMEM_BYTES = 4096
) (
   input logic clk,
   input logic rst,
   input logic enable
);
   localparam int IAW = $clog2(IMEM_BYTES);
   localparam int DAW = $clog2(DMEM_BYTES);

   fsm_state_t  fsm_state, next_state;
   logic [31:0] pc, i_addr, i_data, o_data;
   logic [31:0] op_a, op_b, imm, result;
   logic [31:0] imem_rdata, dmem_rdata, rs1_rdata, rs2_rdata, exec_pc;
   logic        st_flag, run_ok, taken;
   decode_t     dec;

   assign run_ok = (enable === 1'b1);
   assign dec    = decode(i_data);

   byte_mem #(.BYTES(IMEM_BYTES)) instr_cache (
      .clk(clk), .word_addr(i_addr[IAW-1:2]), .rdata(imem_rdata), .we(1'b0), .wdata(32'h0)
   );

   byte_mem #(.BYTES(DMEM_BYTES)) data_cache (
      .clk(clk), .word_addr(result[DAW-1:2]), .rdata(dmem_rdata), .we(st_flag), .wdata(o_data)
   );

   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[31:IAW], i_addr[1:0]};

   if (1) begin : r
      logic [31:0] regs [32];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k < 32; k++) regs[k] <= '0;
         end else if (fsm_state == WB && i_data[11:7] != 5'd0) begin
            regs[i_data[11:7]] <= result;
         end
      end
      assign rs1_rdata = regs[i_data[19:15]];
      assign rs2_rdata = regs[i_data[24:20]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm_state <= IDLE;
      else     fsm_state <= next_state;
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      next_state = fsm_state;
      case (fsm_state)
         IDLE:   if (run_ok) next_state = FETCH;
         FETCH:  next_state = run_ok ? DECODE : IDLE;
         DECODE: next_state = (dec.kind == K_ILLEGAL || $isunknown(i_data)) ? HALT : EXEC;
         EXEC: begin
            case (dec.kind)
               K_BRANCH:        next_state = FETCH;
               K_LOAD, K_STORE: next_state = MEM;
               default:         next_state = WB;
            endcase
         end
         MEM:     next_state = (dec.kind == K_LOAD) ? WB : FETCH;
         WB:      next_state = FETCH;
         HALT:    next_state = HALT;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      taken   = (dec.kind == K_JAL) || (dec.kind == K_BRANCH && ((op_a == op_b) != dec.br_ne));
      exec_pc = taken ? pc + imm : pc + 32'd4;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= '0;
         i_addr  <= '0;
         i_data  <= '0;
         o_data  <= '0;
         op_a    <= '0;
         op_b    <= '0;
         imm     <= '0;
         result  <= '0;
         st_flag <= 1'b0;
      end else begin
         case (fsm_state)
            FETCH: if (run_ok) i_data <= imem_rdata;
            DECODE: begin
               op_a <= rs1_rdata;
               op_b <= rs2_rdata;
               imm  <= dec.imm;
            end
            EXEC: begin
               pc     <= exec_pc;
               i_addr <= exec_pc;
               // JAL writes the link address; everything else writes the ALU result.
               result <= (dec.kind == K_JAL) ? pc + 32'd4
                                             : alu(dec.alu_op, op_a, dec.use_imm ? imm : op_b);
               if (dec.kind == K_STORE) begin
                  st_flag <= 1'b1;
                  o_data  <= op_b;
               end
            end
            MEM: begin
               st_flag <= 1'b0;
               if (dec.kind == K_LOAD) result <= dmem_rdata;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_control.sv
// Directed self-checking bench for cpu_control: small programs with hand-computed results.
module tb_cpu_control;
   import cpu_control_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   st_count = 0;
   int   lat;
   logic [31:0] prog [$];

   cpu_control dut (.clk(clk), .rst(rst), .enable(enable));

   always #5 clk = ~clk;
   always @(negedge clk) if (dut.st_flag === 1'b1) st_count++;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
      return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
   endfunction

   function automatic logic [31:0] dmem_word(input int a);
      return {dut.data_cache.memory_bank[a], dut.data_cache.memory_bank[a+1],
              dut.data_cache.memory_bank[a+2], dut.data_cache.memory_bank[a+3]};
   endfunction

   // Reset, wipe instruction memory, load the program and leave the core in IDLE.
   task automatic start_prog(input logic [31:0] p [$]);
      rst = 1'b1;
      enable = 1'b0;
      for (int i = 0; i < 4096; i++) dut.instr_cache.memory_bank[i] = 8'h00;
      for (int i = 0; i < p.size(); i++) begin
         dut.instr_cache.memory_bank[4*i]   = p[i][31:24];
         dut.instr_cache.memory_bank[4*i+1] = p[i][23:16];
         dut.instr_cache.memory_bank[4*i+2] = p[i][15:8];
         dut.instr_cache.memory_bank[4*i+3] = p[i][7:0];
      end
      tick;
      tick;
      rst = 1'b0;
      tick;
   endtask

   // Called while in FETCH; returns cycles until the next FETCH (or HALT).
   task automatic wait_fetch(output int n);
      tick;
      n = 1;
      while (dut.fsm_state !== FETCH && dut.fsm_state !== HALT && n < 50) begin
         tick;
         n++;
      end
   endtask

   task automatic run_to_halt(input string tag);
      int n = 0;
      while (dut.fsm_state !== HALT && n < 500) begin
         tick;
         n++;
      end
      check(tag, 32'(dut.fsm_state), 32'(HALT));
   endtask

   initial begin
      #1;
      // Basic stores and halt on a zero word.
      prog = '{addi(5, 0, 32'd7), addi(6, 0, 32'd9), enc_s(32'd4, 5, 0), enc_s(32'd8, 6, 0),
               32'h0};
      start_prog(prog);
      check("reset_pc", dut.pc, 32'h0);
      check("reset_state", 32'(dut.fsm_state), 32'(IDLE));
      check("reset_st_flag", 32'(dut.st_flag), 32'h0);
      st_count = 0;
      enable = 1'b1;
      tick;
      check("a_fetch", 32'(dut.fsm_state), 32'(FETCH));
      wait_fetch(lat);
      check("a_addi_latency", lat, 4);
      wait_fetch(lat);
      wait_fetch(lat);
      check("a_sw_latency", lat, 4);
      wait_fetch(lat);
      run_to_halt("a_halt");
      check("a_mem4", dmem_word(4), 32'd7);
      check("a_mem8", dmem_word(8), 32'd9);
      check("a_x5", dut.r.regs[5], 32'd7);
      check("a_x6", dut.r.regs[6], 32'd9);
      check("a_st_flag_cycles", st_count, 2);
      repeat (3) tick;
      check("a_halt_sticky", 32'(dut.fsm_state), 32'(HALT));

      // Store then load back a full word, then double it.
      prog = '{{20'h12345, 5'd1, 7'b0110111}, addi(1, 1, 32'h678), enc_s(32'd12, 1, 0),
               enc_i(32'd12, 0, 3'b010, 7, 7'b0000011), enc_r(7'b0, 7, 7, 3'b000, 8), 32'h0};
      start_prog(prog);
      enable = 1'b1;
      tick;
      wait_fetch(lat);
      check("b_lui_latency", lat, 4);
      check("b_lui_x1", dut.r.regs[1], 32'h12345000);
      wait_fetch(lat);
      wait_fetch(lat);
      wait_fetch(lat);
      check("b_lw_latency", lat, 5);
      run_to_halt("b_halt");
      check("b_byte12", 32'(dut.data_cache.memory_bank[12]), 32'h12);
      check("b_byte13", 32'(dut.data_cache.memory_bank[13]), 32'h34);
      check("b_byte14", 32'(dut.data_cache.memory_bank[14]), 32'h56);
      check("b_byte15", 32'(dut.data_cache.memory_bank[15]), 32'h78);
      check("b_x7", dut.r.regs[7], 32'h12345678);
      check("b_x8", dut.r.regs[8], 32'h2468ACF0);

      // Counting loop closed by BNE.
      prog = '{addi(6, 0, 32'd3), addi(5, 5, 32'd1), enc_b(32'hFFFFFFFC, 6, 5, 3'b001), 32'h0};
      start_prog(prog);
      enable = 1'b1;
      tick;
      wait_fetch(lat);
      wait_fetch(lat);
      wait_fetch(lat);
      check("c_bne_latency", lat, 3);
      check("c_bne_target", dut.pc, 32'd4);
      run_to_halt("c_halt");
      check("c_x5", dut.r.regs[5], 32'd3);
      check("c_halt_pc", dut.pc, 32'd12);

      // x0 stays zero; negative immediate.
      prog = '{addi(0, 0, 32'd5), addi(5, 0, 32'hFFFFFFFF), 32'h0};
      start_prog(prog);
      enable = 1'b1;
      run_to_halt("d_halt");
      check("d_x0", dut.r.regs[0], 32'h0);
      check("d_x5", dut.r.regs[5], 32'hFFFFFFFF);

      // JAL, BEQ and the remaining ALU operations.
      prog = '{enc_j(32'd8, 1), addi(2, 0, 32'd1), enc_b(32'd8, 0, 0, 3'b000), addi(3, 0, 32'd1),
               enc_r(7'b0100000, 1, 0, 3'b000, 4), enc_r(7'b0, 0, 4, 3'b010, 10),
               enc_r(7'b0, 1, 4, 3'b101, 11), enc_r(7'b0, 1, 1, 3'b001, 12),
               enc_i(32'hFFFFFFFF, 4, 3'b100, 13, 7'b0010011),
               enc_i(32'd3, 1, 3'b110, 14, 7'b0010011),
               enc_i(32'h0F0, 4, 3'b111, 15, 7'b0010011),
               enc_i(32'hFFFFFFFF, 1, 3'b010, 16, 7'b0010011), 32'h0};
      start_prog(prog);
      enable = 1'b1;
      tick;
      wait_fetch(lat);
      check("e_jal_latency", lat, 4);
      check("e_jal_target", dut.pc, 32'd8);
      wait_fetch(lat);
      check("e_beq_latency", lat, 3);
      check("e_beq_target", dut.pc, 32'd16);
      run_to_halt("e_halt");
      check("e_x1_link", dut.r.regs[1], 32'd4);
      check("e_x2_skipped", dut.r.regs[2], 32'd0);
      check("e_x3_skipped", dut.r.regs[3], 32'd0);
      check("e_sub", dut.r.regs[4], 32'hFFFFFFFC);
      check("e_slt", dut.r.regs[10], 32'd1);
      check("e_srl", dut.r.regs[11], 32'h0FFFFFFF);
      check("e_sll", dut.r.regs[12], 32'd64);
      check("e_xori", dut.r.regs[13], 32'd3);
      check("e_ori", dut.r.regs[14], 32'd7);
      check("e_andi", dut.r.regs[15], 32'h000000F0);
      check("e_slti", dut.r.regs[16], 32'd0);

      // Stalled core, enable drop at FETCH, and reset during a store's MEM cycle.
      prog = '{addi(5, 0, 32'h55), enc_s(32'd16, 5, 0), 32'h0};
      start_prog(prog);
      repeat (8) tick;
      check("f_stall_pc", dut.pc, 32'h0);
      check("f_stall_state", 32'(dut.fsm_state), 32'(IDLE));
      enable = 1'b1;
      tick;
      enable = 1'b0;
      tick;
      check("f_fetch_to_idle", 32'(dut.fsm_state), 32'(IDLE));
      enable = 1'b1;
      lat = 0;
      while (dut.fsm_state !== MEM && lat < 50) begin
         tick;
         lat++;
      end
      check("f_reached_mem", 32'(dut.fsm_state), 32'(MEM));
      check("f_st_flag_in_mem", 32'(dut.st_flag), 32'h1);
      rst = 1'b1;
      #1;
      check("f_async_st_flag", 32'(dut.st_flag), 32'h0);
      check("f_async_state", 32'(dut.fsm_state), 32'(IDLE));
      check("f_async_pc", dut.pc, 32'h0);
      check("f_async_i_addr", dut.i_addr, 32'h0);
      check("f_async_i_data", dut.i_data, 32'h0);
      check("f_async_o_data", dut.o_data, 32'h0);
      check("f_async_x5", dut.r.regs[5], 32'h0);
      tick;
      tick;
      rst = 1'b0;
      tick;
      check("f_no_store", dmem_word(16), 32'h0);
      check("f_pc_after", dut.pc, 32'h0);

      // MUL encoding: executes with the option, halts without it.
      prog = '{addi(5, 0, 32'd7), addi(6, 0, 32'd9), enc_r(7'b0000001, 6, 5, 3'b000, 9), 32'h0};
      start_prog(prog);
      enable = 1'b1;
      tick;
      wait_fetch(lat);
      wait_fetch(lat);
`ifdef CPU_CONTROL_MUL_EN
      wait_fetch(lat);
      check("g_mul_latency", lat, 4);
      run_to_halt("g_halt");
      check("g_mul_x9", dut.r.regs[9], 32'd63);
      check("g_halt_pc", dut.pc, 32'd12);
`else
      run_to_halt("g_halt");
      check("g_mul_x9", dut.r.regs[9], 32'd0);
      check("g_halt_pc", dut.pc, 32'd8);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
